// File: rtl/movegen_sequencer_pkg.sv
// Shared types for the move-generation sequencer: FSM states and array command codes.
package movegen_sequencer_pkg;

`include "cmd.vh"

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_INIT    = 3'd1,
      ST_FV      = 3'd2,
      ST_FA      = 3'd3,
      ST_EMIT    = 3'd4,
      ST_DIS_AGG = 3'd5,
      ST_DIS_VIC = 3'd6,
      ST_FINISH  = 3'd7
   } mg_state_e;

endpackage

// File: rtl/cmd.vh
// Array and mask command encodings shared by the sequencer and the square array.
`ifndef MOVEGEN_CMD_VH
`define MOVEGEN_CMD_VH

localparam logic [2:0] SM_FV      = 3'd1;
localparam logic [2:0] SM_FA      = 3'd2;

localparam logic [1:0] MM_NOP     = 2'd0;
localparam logic [1:0] MM_EAV_EAA = 2'd1;
localparam logic [1:0] MM_DA      = 2'd2;
localparam logic [1:0] MM_DV_EAA  = 2'd3;

`endif

// File: rtl/movegen_counter.sv
// 8-bit move counter: synchronous clear has priority, increment saturates at 255.
// Single-cycle update, no backpressure.
module movegen_counter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_clr,
   input  logic       i_inc,
   output logic [7:0] o_count
);

   logic [7:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= 8'd0;
      end else if (i_clr) begin
         r_count <= 8'd0;
      end else if (i_inc && (r_count != 8'hFF)) begin
         r_count <= r_count + 8'd1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/movegen_sequencer.sv
// Sequences find-victim / find-aggressor searches over the square array and streams moves.
// Outputs are registered from the next state; EMIT stalls on move_ready, abort wins over everything.
module movegen_sequencer
   import movegen_sequencer_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       wtm_in,
   input  logic       abort,
   input  logic [2:0] best_prio,
   input  logic [5:0] best_sq,
   input  logic       any_king,
   output logic [2:0] state_mode,
   output logic [1:0] mask_mode,
   output logic       wtm,
   output logic [5:0] ss1_sq,
   output logic       ss1_en,
   output logic       move_valid,
   input  logic       move_ready,
   output logic [5:0] move_from,
   output logic [5:0] move_to,
   output logic       done,
   output logic       illegal,
   output logic [7:0] move_count
);

   mg_state_e  r_state;
   mg_state_e  w_state_nxt;
   logic [5:0] r_victim;
   logic [5:0] r_aggr;
   logic [5:0] w_victim_nxt;
   logic [5:0] w_aggr_nxt;
   logic       w_illegal_nxt;
   logic       w_start_acc;
   logic       w_inc;
   logic [2:0] w_sm;
   logic [1:0] w_mm;
   logic [5:0] w_ss1_sq;
   logic       w_ss1_en;
   logic       w_valid;
   logic       w_done;

   logic [2:0] r_sm;
   logic [1:0] r_mm;
   logic       r_wtm;
   logic [5:0] r_ss1_sq;
   logic       r_ss1_en;
   logic       r_valid;
   logic [5:0] r_from;
   logic [5:0] r_to;
   logic       r_done;
   logic       r_illegal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Outputs decode from the next state so each command appears during its own state's cycle.
   always_comb begin
      w_state_nxt   = r_state;
      w_victim_nxt  = r_victim;
      w_aggr_nxt    = r_aggr;
      w_illegal_nxt = r_illegal;
      w_start_acc   = 1'b0;
      w_inc         = 1'b0;
      w_sm          = SM_FV;
      w_mm          = MM_NOP;
      w_ss1_sq      = 6'd0;
      w_ss1_en      = 1'b0;
      w_valid       = 1'b0;
      w_done        = 1'b0;

      if (abort) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  w_state_nxt   = ST_INIT;
                  w_start_acc   = 1'b1;
                  w_illegal_nxt = 1'b0;
               end
            end
            ST_INIT:    w_state_nxt = ST_FV;
            ST_FV: begin
               if (any_king) begin
                  w_illegal_nxt = 1'b1;
                  w_state_nxt   = ST_FINISH;
               end else if (best_prio == 3'd0) begin
                  w_state_nxt = ST_FINISH;
               end else begin
                  w_victim_nxt = best_sq;
                  w_state_nxt  = ST_FA;
               end
            end
            ST_FA: begin
               if (best_prio == 3'd0) begin
                  w_state_nxt = ST_DIS_VIC;
               end else begin
                  w_aggr_nxt  = best_sq;
                  w_state_nxt = ST_EMIT;
               end
            end
            ST_EMIT: begin
               if (move_ready) begin
                  w_inc       = 1'b1;
                  w_state_nxt = ST_DIS_AGG;
               end
            end
            ST_DIS_AGG: w_state_nxt = ST_FA;
            ST_DIS_VIC: w_state_nxt = ST_FV;
            ST_FINISH:  w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
         endcase
      end

      case (w_state_nxt)
         ST_INIT: w_mm = MM_EAV_EAA;
         ST_FA: begin
            w_sm     = SM_FA;
            w_ss1_sq = w_victim_nxt;
            w_ss1_en = 1'b1;
         end
         ST_EMIT: begin
            w_sm    = SM_FA;
            w_valid = 1'b1;
         end
         ST_DIS_AGG: begin
            w_sm     = SM_FA;
            w_mm     = MM_DA;
            w_ss1_sq = w_aggr_nxt;
            w_ss1_en = 1'b1;
         end
         ST_DIS_VIC: begin
            w_mm     = MM_DV_EAA;
            w_ss1_sq = w_victim_nxt;
            w_ss1_en = 1'b1;
         end
         ST_FINISH: w_done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_victim  <= 6'd0;
         r_aggr    <= 6'd0;
         r_sm      <= SM_FV;
         r_mm      <= MM_NOP;
         r_wtm     <= 1'b0;
         r_ss1_sq  <= 6'd0;
         r_ss1_en  <= 1'b0;
         r_valid   <= 1'b0;
         r_from    <= 6'd0;
         r_to      <= 6'd0;
         r_done    <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         r_victim  <= w_victim_nxt;
         r_aggr    <= w_aggr_nxt;
         r_sm      <= w_sm;
         r_mm      <= w_mm;
         r_ss1_sq  <= w_ss1_sq;
         r_ss1_en  <= w_ss1_en;
         r_valid   <= w_valid;
         r_from    <= w_aggr_nxt;
         r_to      <= w_victim_nxt;
         r_done    <= w_done;
         r_illegal <= w_illegal_nxt;
         if (w_start_acc) begin
            r_wtm <= wtm_in;
         end
      end
   end

   movegen_counter u_counter (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (w_start_acc),
      .i_inc   (w_inc),
      .o_count (move_count)
   );

   assign state_mode = r_sm;
   assign mask_mode  = r_mm;
   assign wtm        = r_wtm;
   assign ss1_sq     = r_ss1_sq;
   assign ss1_en     = r_ss1_en;
   assign move_valid = r_valid;
   assign move_from  = r_from;
   assign move_to    = r_to;
   assign done       = r_done;
   assign illegal    = r_illegal;

endmodule

// File: tb/tb_movegen_sequencer.sv
// Directed bench for movegen_sequencer with hand-computed expectations.
module tb_movegen_sequencer;
   import movegen_sequencer_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       wtm_in;
   logic       abort;
   logic [2:0] best_prio;
   logic [5:0] best_sq;
   logic       any_king;
   logic [2:0] state_mode;
   logic [1:0] mask_mode;
   logic       wtm;
   logic [5:0] ss1_sq;
   logic       ss1_en;
   logic       move_valid;
   logic       move_ready;
   logic [5:0] move_from;
   logic [5:0] move_to;
   logic       done;
   logic       illegal;
   logic [7:0] move_count;

   int n_checks = 0;
   int n_pass   = 0;

   movegen_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .wtm_in     (wtm_in),
      .abort      (abort),
      .best_prio  (best_prio),
      .best_sq    (best_sq),
      .any_king   (any_king),
      .state_mode (state_mode),
      .mask_mode  (mask_mode),
      .wtm        (wtm),
      .ss1_sq     (ss1_sq),
      .ss1_en     (ss1_en),
      .move_valid (move_valid),
      .move_ready (move_ready),
      .move_from  (move_from),
      .move_to    (move_to),
      .done       (done),
      .illegal    (illegal),
      .move_count (move_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b1; start = 1'b0; wtm_in = 1'b0; abort = 1'b0;
      best_prio = 3'd0; best_sq = 6'd0; any_king = 1'b0; move_ready = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      check("rst_sm",    32'(state_mode), 32'(SM_FV));
      check("rst_mm",    32'(mask_mode),  32'(MM_NOP));
      check("rst_valid", 32'(move_valid), 0);
      check("rst_count", 32'(move_count), 0);
      check("rst_done",  32'(done), 0);
      #9 rst_n = 1'b1;

      // Single move, then victim exhausted, then search exhausted
      start = 1'b1; wtm_in = 1'b0;
      tick(); start = 1'b0;
      check("init_mm", 32'(mask_mode), 32'(MM_EAV_EAA));
      tick();
      check("fv_sm", 32'(state_mode), 32'(SM_FV));
      check("fv_en", 32'(ss1_en), 0);
      best_prio = 3'd5; best_sq = 6'd28;
      tick();
      check("fa_sm", 32'(state_mode), 32'(SM_FA));
      check("fa_sq", 32'(ss1_sq), 28);
      check("fa_en", 32'(ss1_en), 1);
      best_prio = 3'd6; best_sq = 6'd0;
      tick();
      check("emit_valid", 32'(move_valid), 1);
      check("emit_from",  32'(move_from), 0);
      check("emit_to",    32'(move_to), 28);
      move_ready = 1'b1; best_prio = 3'd0;
      tick(); move_ready = 1'b0;
      check("da_valid", 32'(move_valid), 0);
      check("da_count", 32'(move_count), 1);
      check("da_mm",    32'(mask_mode), 32'(MM_DA));
      check("da_sq",    32'(ss1_sq), 0);
      tick();
      check("fa2_sq", 32'(ss1_sq), 28);
      tick();
      check("dv_mm", 32'(mask_mode), 32'(MM_DV_EAA));
      check("dv_sq", 32'(ss1_sq), 28);
      check("dv_en", 32'(ss1_en), 1);
      tick();
      check("fv2_sm", 32'(state_mode), 32'(SM_FV));
      check("fv2_mm", 32'(mask_mode), 32'(MM_NOP));
      tick();
      check("fin_done",  32'(done), 1);
      check("fin_count", 32'(move_count), 1);
      tick();
      check("idle_done", 32'(done), 0);

      // No victim on first search
      start = 1'b1; wtm_in = 1'b1;
      tick(); start = 1'b0;
      check("b_wtm",   32'(wtm), 1);
      check("b_count", 32'(move_count), 0);
      tick(); tick();
      check("b_done",    32'(done), 1);
      check("b_illegal", 32'(illegal), 0);
      tick();
      check("b_done_off", 32'(done), 0);

      // King capturable
      start = 1'b1;
      tick(); start = 1'b0;
      tick();
      any_king = 1'b1; best_prio = 3'd3;
      tick(); any_king = 1'b0; best_prio = 3'd0;
      check("c_illegal", 32'(illegal), 1);
      check("c_done",    32'(done), 1);
      check("c_valid",   32'(move_valid), 0);
      tick();
      check("c_ill_hold", 32'(illegal), 1);
      start = 1'b1;
      tick(); start = 1'b0;
      check("c_ill_clr", 32'(illegal), 0);

      // Stalled handshake then abort in EMIT
      tick();
      best_prio = 3'd2; best_sq = 6'd10;
      tick();
      best_prio = 3'd4; best_sq = 6'd50;
      tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_valid", 32'(move_valid), 1);
         check("stall_from",  32'(move_from), 50);
         check("stall_to",    32'(move_to), 10);
         check("stall_count", 32'(move_count), 0);
      end
      move_ready = 1'b1;
      tick(); move_ready = 1'b0;
      check("stall_done_count", 32'(move_count), 1);
      tick(); tick();
      check("d_emit_valid", 32'(move_valid), 1);
      abort = 1'b1; move_ready = 1'b1;
      tick(); abort = 1'b0; move_ready = 1'b0;
      check("abort_valid", 32'(move_valid), 0);
      check("abort_count", 32'(move_count), 1);
      check("abort_done",  32'(done), 0);
      check("abort_sm",    32'(state_mode), 32'(SM_FV));
      tick();
      check("abort_idle_done", 32'(done), 0);

      // start together with abort in IDLE is dropped
      start = 1'b1; abort = 1'b1;
      tick(); start = 1'b0; abort = 1'b0;
      check("sa_mm", 32'(mask_mode), 32'(MM_NOP));
      tick();
      check("sa_mm2", 32'(mask_mode), 32'(MM_NOP));

      // Asynchronous reset while in FA
      start = 1'b1; wtm_in = 1'b1;
      tick(); start = 1'b0;
      tick();
      best_prio = 3'd1; best_sq = 6'd33;
      tick();
      check("r_fa_en", 32'(ss1_en), 1);
      #2 rst_n = 1'b0;
      #1;
      check("ar_sm",      32'(state_mode), 32'(SM_FV));
      check("ar_mm",      32'(mask_mode), 32'(MM_NOP));
      check("ar_wtm",     32'(wtm), 0);
      check("ar_ss1_sq",  32'(ss1_sq), 0);
      check("ar_ss1_en",  32'(ss1_en), 0);
      check("ar_valid",   32'(move_valid), 0);
      check("ar_from",    32'(move_from), 0);
      check("ar_to",      32'(move_to), 0);
      check("ar_done",    32'(done), 0);
      check("ar_illegal", 32'(illegal), 0);
      check("ar_count",   32'(move_count), 0);
      rst_n = 1'b1;
      tick();
      check("ar_post_en", 32'(ss1_en), 0);

      // Counter saturation
      start = 1'b1;
      tick(); start = 1'b0;
      tick();
      best_prio = 3'd1; best_sq = 6'd5;
      tick();
      best_prio = 3'd2; best_sq = 6'd7; move_ready = 1'b1;
      for (int i = 0; i < 255; i++) begin
         tick(); tick(); tick();
      end
      check("sat_255", 32'(move_count), 255);
      for (int i = 0; i < 3; i++) begin
         tick(); tick(); tick();
      end
      check("sat_hold", 32'(move_count), 255);
      abort = 1'b1; move_ready = 1'b0;
      tick(); abort = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
